// File: rtl/reg12_write_arbiter.sv
// rtl/reg12_write_arbiter.sv - round-robin write arbiter for a shared 12-bit Ce-enabled register
module reg12_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 12
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [N_REQ-1:0]   Req,
  input  logic [N_REQ*DW-1:0] Din_all,
  output logic [DW-1:0]      Reg_Din,
  output logic               Reg_Ce,
  output logic [N_REQ-1:0]   Ack,
  output logic [1:0]         Gnt_id,
  output logic               Busy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] ACK   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [N_REQ-1:0] served_q, served_d;
  logic [DW-1:0]    din_q, din_d;
  logic             ce_q, ce_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [1:0]       gnt_q, gnt_d;
  logic             busy_q, busy_d;

  logic [N_REQ-1:0] elig;
  logic             win_found;
  logic [1:0]       win_id;

  assign elig = Req & ~served_q;

  // Search starts at ptr_q; 2-bit index arithmetic gives the mod-4 wrap.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win_id    = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      idx = ptr_q + 2'(i);
      if (!win_found && elig[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    served_d = served_q & Req;
    din_d    = din_q;
    ce_d     = 1'b0;
    ack_d    = '0;
    gnt_d    = gnt_q;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = GRANT;
          ce_d    = 1'b1;
          din_d   = Din_all[win_id*DW +: DW];
          gnt_d   = win_id;
          busy_d  = 1'b1;
        end
      end
      GRANT: begin
        state_d       = ACK;
        ack_d[gnt_q]  = 1'b1;
      end
      ACK: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        ptr_d   = gnt_q + 2'd1;
        // A winner still holding Req must drop it before it can win again.
        if (Req[gnt_q]) served_d[gnt_q] = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      served_q <= '0;
      din_q    <= '0;
      ce_q     <= 1'b0;
      ack_q    <= '0;
      gnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      served_q <= served_d;
      din_q    <= din_d;
      ce_q     <= ce_d;
      ack_q    <= ack_d;
      gnt_q    <= gnt_d;
      busy_q   <= busy_d;
    end
  end

  assign Reg_Din = din_q;
  assign Reg_Ce  = ce_q;
  assign Ack     = ack_q;
  assign Gnt_id  = gnt_q;
  assign Busy    = busy_q;

endmodule
